sync_mod_counter: RTL and testbench
===================================

Name: sync_mod_counter

Overview:
Parametrised modulo-M up/down counter with a synchronised clear input, parallel load, wrap/saturate mode and a terminal-count pulse. It is the next generation of the team's synchronised-reset counter, used for IR pulse-width timing, digit and seconds counters, and button-repeat timers in the vcr_remote design. The block runs on one clock and contains its own configurable-depth synchroniser for the asynchronous-source clear condition.

Parameters:
N, 6, counter width in bits; MODULUS must satisfy 2 <= MODULUS <= 2**N
MODULUS, 60, count range 0..MODULUS-1
WRAP, 1, 1 = wrap at bounds; 0 = saturate at bounds
SYNC_STAGES, 2, flop depth of the i_clear synchroniser; legal range 1..4

Ports:
i_clk  input  1  system clock; all flops are rising-edge
i_reset  input  1  synchronous, active-high reset
i_clear  input  1  asynchronous-source clear request (button or cross-domain condition); passes through the synchroniser
i_enable  input  1  count-step enable, one step per enabled cycle
i_up  input  1  direction: 1 = increment, 0 = decrement
i_load  input  1  synchronous parallel load strobe
i_load_value  input  N  value to load
o_count  output  N  current count, registered
o_tc  output  1  registered one-cycle terminal-count pulse
o_at_max  output  1  combinational: o_count == MODULUS-1
o_at_zero  output  1  combinational: o_count == 0

Behaviour:
- Interface: one clock (i_clk). Reset (i_reset) is synchronous and active-high. No other clock or reset exists.
- Reset: on an edge with i_reset=1, o_count=0, o_tc=0 and every synchroniser stage=0. Reset overrides all other inputs.
- Synchroniser: a chain s[0..SYNC_STAGES-1] with s[0]<=i_clear and s[k]<=s[k-1]; clr_sync = s[SYNC_STAGES-1].
  - If i_clear rises before edge 1, clr_sync is first high after edge SYNC_STAGES.
  - o_count reads 0 after edge SYNC_STAGES+1.
  - A pulse of i_clear shorter than one clock may be missed; it is not guaranteed to be captured.
- Priority per edge: i_reset > clr_sync > i_load > i_enable > hold.
- Clear: while clr_sync=1, o_count<=0 and o_tc<=0. Clear is level-held, so the counter stays at 0 while clr_sync remains 1.
- Load: o_count<=i_load_value, and o_tc<=0. If i_load_value >= MODULUS, o_count<=MODULUS-1 (clamp). i_enable is ignored in a load cycle.
- Count up (i_enable=1, i_up=1):
  - count < MODULUS-1: count+1.
  - count == MODULUS-1 and WRAP=1: count<=0, o_tc<=1.
  - count == MODULUS-1 and WRAP=0: count holds, o_tc<=1.
- Count down (i_enable=1, i_up=0):
  - count > 0: count-1.
  - count == 0 and WRAP=1: count<=MODULUS-1, o_tc<=1.
  - count == 0 and WRAP=0: count holds, o_tc<=1.
- o_tc is low on every edge not listed above.
  - o_tc is high for exactly the cycle after the boundary step.
  - If i_enable stays high at the bound with WRAP=0, o_tc repeats every cycle.
- Arithmetic: all comparisons are N-bit unsigned. No intermediate value may exceed N bits. MODULUS = 2**N must work, with the wrap done through the compare and not through natural overflow.
- Direction change takes effect on the same edge as i_up. There is no pipeline latency: the step latency is one edge.
- Reset asserted mid-count or mid-synchronisation discards any pending clear in the chain.
- Elaboration fails on an illegal parameter: MODULUS > 2**N, MODULUS < 2, or SYNC_STAGES outside 1..4.

Test Plan:
- Reset/up-wrap: N=6, MODULUS=60, WRAP=1. Pulse i_reset, then hold i_enable=1, i_up=1 for 60 cycles -> count goes 0..59 then back to 0; o_tc is high for one cycle after the 59->0 edge; o_at_max is high only at 59.
- Down-wrap and saturate: with WRAP=1, start from 0 with i_up=0 -> count 59 and o_tc=1. With WRAP=0, start at 0 and decrement for 3 cycles -> count stays 0 and o_tc stays high for all 3 cycles.
- Sync clear latency: SYNC_STAGES=2, count=25, raise i_clear before edge 1 -> count is still 25 or higher after edge 2 and reads 0 after edge 3. Repeat with SYNC_STAGES=4 -> count reads 0 after edge 5.
- Priority: assert i_clear (already synced), i_load=1 with value 10, and i_enable=1 on the same edge -> count=0. Then load alone with value 10 -> count=10. Then load with value 63 -> count clamps to 59.
- Reset mid-sync: raise i_clear for 1 cycle, then assert i_reset on the next edge -> the chain is flushed and no late clear occurs; after reset, enabled counting proceeds 0,1,2.
- Full range: N=4, MODULUS=16, WRAP=1, up for 16 cycles -> 15->0 wrap with o_tc=1 and no width overflow artefacts.

Source files
------------

// File: rtl/sync_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_mod_counter
// Purpose  : Modulo-MODULUS up/down counter. It has a synchronised clear, a
//            parallel load with clamping, wrap or saturate behaviour at the
//            bounds, and a registered terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_mod_counter #(
   parameter int N           = 6,
   parameter int MODULUS     = 60,
   parameter bit WRAP        = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic         i_up,
   input  logic         i_load,
   input  logic [N-1:0] i_load_value,
   output logic [N-1:0] o_count,
   output logic         o_tc,
   output logic         o_at_max,
   output logic         o_at_zero
);

   // Upper bound held in N bits. MODULUS itself may be 2**N, which does not
   // fit, so every bound test is made against MODULUS-1 instead.
   localparam logic [N-1:0] MAX_COUNT = N'(MODULUS - 1);
   localparam logic [N-1:0] ONE       = N'(1);

   // Reject parameter sets that cannot describe a valid counter
   generate
      if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << N))) begin : g_bad_modulus
         $error("sync_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**N");
      end
      if ((SYNC_STAGES < 1) || (SYNC_STAGES > 4)) begin : g_bad_sync
         $error("sync_mod_counter: SYNC_STAGES must be in 1..4");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   clr_sync;
   logic [N-1:0]           count_q;
   logic [N-1:0]           count_d;
   logic                   tc_q;
   logic                   tc_d;
   logic [N-1:0]           load_clamped;

   assign clr_sync = sync_q[SYNC_STAGES-1];

   // Clear-request synchroniser; reset flushes any request still in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= i_clear;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Out-of-range load values are pinned to the top of the count range
   assign load_clamped = (i_load_value > MAX_COUNT) ? MAX_COUNT : i_load_value;

   // Next-state selection in priority order: clear, load, step, hold
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (clr_sync) begin
         count_d = '0;
      end else if (i_load) begin
         count_d = load_clamped;
      end else if (i_enable) begin
         if (i_up) begin
            if (count_q == MAX_COUNT) begin
               // The wrap comes from this compare. The adder never overflows.
               count_d = WRAP ? '0 : count_q;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + ONE;
            end
         end else begin
            if (count_q == '0) begin
               count_d = WRAP ? MAX_COUNT : count_q;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - ONE;
            end
         end
      end
   end

   // Count and terminal-count registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign o_count   = count_q;
   assign o_tc      = tc_q;
   assign o_at_max  = (count_q == MAX_COUNT);
   assign o_at_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_sync_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_mod_counter
// Purpose  : Self-checking bench. Four counter variants share one stimulus
//            stream and are compared every cycle against a behavioural model.
//            Directed literal checks pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_mod_counter;

   localparam int NI = 4;
   // Variant table: 0 = 6b/60/wrap/2, 1 = 6b/60/sat/2, 2 = 6b/60/wrap/4,
   // 3 = 4b/16/wrap/2
   localparam int P_N [NI] = '{6, 6, 6, 4};
   localparam int P_M [NI] = '{60, 60, 60, 16};
   localparam int P_W [NI] = '{1, 0, 1, 1};
   localparam int P_S [NI] = '{2, 2, 4, 2};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic       enable = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_value = '0;

   logic [5:0] cnt [0:2];
   logic [3:0] cnt3;
   logic       tc    [0:3];
   logic       amax  [0:3];
   logic       azero [0:3];

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   // Model state
   int mc [NI];
   int mt [NI];
   int edge_n = 0;
   int last_rst = 0;
   bit clr_hist [0:4095];

   always #5 clk = ~clk;

   sync_mod_counter #(.N(6), .MODULUS(60), .WRAP(1'b1), .SYNC_STAGES(2)) u0 (
      .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_enable(enable), .i_up(up),
      .i_load(load), .i_load_value(load_value), .o_count(cnt[0]), .o_tc(tc[0]),
      .o_at_max(amax[0]), .o_at_zero(azero[0]));

   sync_mod_counter #(.N(6), .MODULUS(60), .WRAP(1'b0), .SYNC_STAGES(2)) u1 (
      .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_enable(enable), .i_up(up),
      .i_load(load), .i_load_value(load_value), .o_count(cnt[1]), .o_tc(tc[1]),
      .o_at_max(amax[1]), .o_at_zero(azero[1]));

   sync_mod_counter #(.N(6), .MODULUS(60), .WRAP(1'b1), .SYNC_STAGES(4)) u2 (
      .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_enable(enable), .i_up(up),
      .i_load(load), .i_load_value(load_value), .o_count(cnt[2]), .o_tc(tc[2]),
      .o_at_max(amax[2]), .o_at_zero(azero[2]));

   sync_mod_counter #(.N(4), .MODULUS(16), .WRAP(1'b1), .SYNC_STAGES(2)) u3 (
      .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_enable(enable), .i_up(up),
      .i_load(load), .i_load_value(load_value[3:0]), .o_count(cnt3), .o_tc(tc[3]),
      .o_at_max(amax[3]), .o_at_zero(azero[3]));

   function automatic int dut_count(input int i);
      case (i)
         0: return int'(cnt[0]);
         1: return int'(cnt[1]);
         2: return int'(cnt[2]);
         default: return int'(cnt3);
      endcase
   endfunction

   // Behavioural model. A clear request reaches the counter S edges after it
   // is sampled, unless a reset occurs at or after the sampling edge.
   always @(posedge clk) begin
      int lv;
      bit clr;
      edge_n++;
      if (edge_n > 4095) begin
         $display("FAIL edge_budget: edge %0d exceeds history limit 4095", edge_n);
         $fatal(1);
      end
      clr_hist[edge_n] = clear;
      if (reset) begin
         last_rst = edge_n;
         for (int i = 0; i < NI; i++) begin
            mc[i] = 0;
            mt[i] = 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            clr = ((edge_n - P_S[i]) > last_rst) && clr_hist[edge_n - P_S[i]];
            mt[i] = 0;
            if (clr) begin
               mc[i] = 0;
            end else if (load) begin
               lv = int'(load_value) % (1 << P_N[i]);
               mc[i] = (lv >= P_M[i]) ? P_M[i] - 1 : lv;
            end else if (enable && up) begin
               if (mc[i] + 1 < P_M[i]) mc[i] = mc[i] + 1;
               else begin
                  mc[i] = P_W[i] ? 0 : mc[i];
                  mt[i] = 1;
               end
            end else if (enable) begin
               if (mc[i] > 0) mc[i] = mc[i] - 1;
               else begin
                  mc[i] = P_W[i] ? P_M[i] - 1 : 0;
                  mt[i] = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison of every variant against the model
   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.count", i), dut_count(i), mc[i]);
            chk($sformatf("u%0d.tc", i), int'(tc[i]), mt[i]);
            chk($sformatf("u%0d.at_max", i), int'(amax[i]), int'(mc[i] == P_M[i] - 1));
            chk($sformatf("u%0d.at_zero", i), int'(azero[i]), int'(mc[i] == 0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checking = 1'b1;
      chk("reset.u0.count", dut_count(0), 0);
      chk("reset.u0.tc", int'(tc[0]), 0);
      chk("reset.u3.at_zero", int'(azero[3]), 1);

      // Up-count through the full range
      enable = 1'b1;
      up = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 15) begin
            chk("full.u3.count15", dut_count(3), 15);
            chk("full.u3.at_max", int'(amax[3]), 1);
         end
         if (k == 16) begin
            chk("full.u3.wrap", dut_count(3), 0);
            chk("full.u3.tc", int'(tc[3]), 1);
         end
         if (k == 59) begin
            chk("up.u0.count59", dut_count(0), 59);
            chk("up.u0.at_max", int'(amax[0]), 1);
            chk("up.u0.tc_pre", int'(tc[0]), 0);
         end
         if (k == 60) begin
            chk("up.u0.wrap", dut_count(0), 0);
            chk("up.u0.tc", int'(tc[0]), 1);
            chk("sat.u1.hold59", dut_count(1), 59);
            chk("sat.u1.tc", int'(tc[1]), 1);
            chk("full.u3.count", dut_count(3), 12);
         end
      end

      // Down-wrap and down-saturate from zero
      enable = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b1;
      up = 1'b0;
      tick();
      chk("down.u0.wrap", dut_count(0), 59);
      chk("down.u0.tc", int'(tc[0]), 1);
      chk("down.u1.hold0", dut_count(1), 0);
      chk("down.u1.tc1", int'(tc[1]), 1);
      tick();
      chk("down.u0.count58", dut_count(0), 58);
      chk("down.u0.tc_off", int'(tc[0]), 0);
      chk("down.u1.tc2", int'(tc[1]), 1);
      tick();
      chk("down.u1.tc3", int'(tc[1]), 1);
      chk("down.u1.still0", dut_count(1), 0);
      enable = 1'b0;

      // Clear latency through the synchroniser
      load = 1'b1;
      load_value = 6'd25;
      tick();
      chk("load.u0.25", dut_count(0), 25);
      chk("load.u3.trunc", dut_count(3), 9);
      load = 1'b0;
      clear = 1'b1;
      tick();
      tick();
      chk("clr.u0.edge2", dut_count(0), 25);
      tick();
      chk("clr.u0.edge3", dut_count(0), 0);
      chk("clr.u2.edge3", dut_count(2), 25);
      tick();
      tick();
      chk("clr.u2.edge5", dut_count(2), 0);

      // Priority: clear beats load and enable
      load = 1'b1;
      load_value = 6'd10;
      enable = 1'b1;
      up = 1'b1;
      tick();
      chk("prio.u0.clear_wins", dut_count(0), 0);
      clear = 1'b0;
      load = 1'b0;
      enable = 1'b0;
      repeat (5) tick();
      load = 1'b1;
      load_value = 6'd10;
      tick();
      chk("prio.u0.load10", dut_count(0), 10);
      load_value = 6'd63;
      tick();
      chk("clamp.u0.59", dut_count(0), 59);
      chk("clamp.u1.59", dut_count(1), 59);
      chk("clamp.u3.15", dut_count(3), 15);
      load = 1'b0;

      // Reset during synchronisation flushes the pending clear
      clear = 1'b1;
      tick();
      clear = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("flush.u2.count0", dut_count(2), 0);
      enable = 1'b1;
      up = 1'b1;
      tick();
      chk("flush.u0.count1", dut_count(0), 1);
      chk("flush.u2.count1", dut_count(2), 1);
      tick();
      chk("flush.u0.count2", dut_count(0), 2);
      chk("flush.u2.count2", dut_count(2), 2);
      tick();
      tick();
      chk("flush.u2.count4", dut_count(2), 4);
      enable = 1'b0;
      tick();

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
